wbus_reg_bank: RTL
==================

WBUS_REG_BANK -- requirements
Module: wbus_reg_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the data width of each register and of WBUS.
REQ-002 SHALL have parameter NREG, default 4, meaning the number of registers in the bank (legal range 2..16).
REQ-003 SHALL have localparam AW = clog2(NREG), meaning the width of the select fields.
REQ-004 SHALL have port CLK  input  1  system clock; all state changes on rising edge.
REQ-005 SHALL have port CLR  input  1  synchronous, active-high reset.
REQ-006 SHALL have port WBUS  inout  WIDTH  shared W bus.
REQ-007 SHALL have port nL  input  1  active-low load strobe (0 = load).
REQ-008 SHALL have port LSEL  input  AW  load / operation target register index.
REQ-009 SHALL have port E  input  1  active-high bus drive enable.
REQ-010 SHALL have port ESEL  input  AW  drive source register index.
REQ-011 SHALL have port OP  input  2  in-place operation on register LSEL: 00 hold, 01 increment, 10 decrement, 11 clear.
REQ-012 SHALL have port ZERO  output  1  combinational flag, 1 when register ESEL equals 0.
REQ-013 SHALL have port WRAP  output  1  registered flag, high for exactly one cycle after an increment or decrement wrapped.

Function
REQ-014 SHALL drive WBUS with register ESEL when E=1 and SHALL drive it high-impedance (all z) when E=0, combinationally.
REQ-015 SHALL load WBUS into register LSEL on a rising CLK edge when nL=0 and CLR=0.
REQ-016 SHALL let nL=0 take priority over OP; OP SHALL be ignored in a load cycle.
REQ-017 SHALL apply OP to register LSEL on a rising edge when nL=1 and CLR=0.
REQ-018 SHALL perform increment and decrement modulo 2^WIDTH: increment of all-ones gives 0, and decrement of 0 gives all-ones.
REQ-019 SHALL set WRAP=1 in the cycle following an increment from all-ones or a decrement from 0, and WRAP=0 otherwise (including load, hold and clear cycles).
REQ-020 SHALL, when E=1 and nL=0 with ESEL != LSEL, perform a single-cycle register-to-register transfer: register LSEL receives the pre-edge value of register ESEL.
REQ-021 SHALL, when E=1 and nL=0 with ESEL == LSEL, leave that register unchanged (self-transfer).
REQ-022 SHALL leave every register not addressed by LSEL unchanged in every cycle.
REQ-023 SHALL treat an LSEL or ESEL value >= NREG as follows: load and OP become no-ops, and a read returns 0 (WBUS is still driven when E=1, and ZERO=1).
REQ-024 SHALL compute ZERO from current register contents and ESEL, independent of E.

Reset
REQ-025 SHALL, on a rising edge with CLR=1, clear all registers to 0 and WRAP to 0, overriding nL and OP.
REQ-026 SHALL keep WBUS output gating governed only by E during reset; with CLR=1 and E=1, WBUS shows the pre-reset value until the edge and 0 after it.
REQ-027 SHALL, when CLR is asserted mid-operation, discard any load or OP presented in that cycle.

Structure
REQ-028 SHALL place the OP encodings (HOLD, INC, DEC, CLR_OP) and the high-impedance constant in the shared SAP-II package.
REQ-029 SHALL use a single sub-module, wbus_reg_cell (one WIDTH-bit register with load / inc / dec / clear and a wrap output), instantiated NREG times, with the bank handling decode, the bus mux and the tristate.

Verification
REQ-030 SHALL cover: CLR=1 for one edge, then E=1 and ESEL=0..3 -> WBUS reads 0x00 and ZERO=1 for every register, and WRAP=0.
REQ-031 SHALL cover: testbench drives 0x0A with nL=0 and LSEL=2, then E=1 and ESEL=2 -> WBUS=0x0A and ZERO=0; with E=0 -> WBUS all z.
REQ-032 SHALL cover: register 1 = 0xFE, then OP=INC twice -> 0xFF then 0x00, with WRAP=1 only in the cycle after the second edge; register 3 = 0x00 with OP=DEC -> 0xFF and WRAP=1.
REQ-033 SHALL cover: register 0 = 0x20, then E=1, ESEL=0, nL=0, LSEL=3 for one edge -> register 3 = 0x20 and register 0 still 0x20.
REQ-034 SHALL cover: nL=0 with OP=INC and bus 0x05 into LSEL=1 -> register 1 = 0x05 (load wins); next cycle CLR=1 with nL=0 and bus 0x77 -> all registers 0.
REQ-035 SHALL cover: OP=CLR_OP on register 2 holding 0x33 -> register 2 = 0 and registers 0, 1, 3 unchanged.

Source files
------------

// File: rtl/wbus_reg_bank_pkg.sv
// Shared definitions for the W-bus register bank: in-place operation codes
// and the high-impedance bit used when the bank releases the bus.
package wbus_reg_bank_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'b00,
        INC    = 2'b01,
        DEC    = 2'b10,
        CLR_OP = 2'b11
    } op_e;

    localparam logic HIZ = 1'bz;

endpackage

// File: rtl/wbus_reg_cell.sv
// One WIDTH-bit bank register with load, increment, decrement and clear.
// wrap pulses for one cycle after an increment or decrement rolls over.
module wbus_reg_cell
    import wbus_reg_bank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             ld,
    input  logic             sel,
    input  logic [WIDTH-1:0] din,
    input  op_e              op,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    // A load outranks the operation; wrap defaults low so it only ever lasts one cycle.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            q    <= '0;
            wrap <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (ld) begin
                q <= din;
            end else if (sel) begin
                case (op)
                    INC: begin
                        q    <= q + WIDTH'(1);
                        wrap <= (q == '1);
                    end
                    DEC: begin
                        q    <= q - WIDTH'(1);
                        wrap <= (q == '0);
                    end
                    CLR_OP:  q <= '0;
                    default: q <= q;
                endcase
            end
        end
    end

endmodule

// File: rtl/wbus_reg_bank.sv
// Register bank on the shared W bus: decodes load/operation targets, muxes the
// selected register onto the bus and releases the bus when not enabled.
module wbus_reg_bank
    import wbus_reg_bank_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int NREG  = 4,
    localparam int AW    = $clog2(NREG)
) (
    input  logic          CLK,
    input  logic          CLR,
    inout  wire [WIDTH-1:0] WBUS,
    input  logic          nL,
    input  logic [AW-1:0] LSEL,
    input  logic          E,
    input  logic [AW-1:0] ESEL,
    input  logic [1:0]    OP,
    output logic          ZERO,
    output logic          WRAP
);

    logic [WIDTH-1:0] regQ [NREG];
    logic [NREG-1:0]  wrapVec;
    logic [NREG-1:0]  ldEn;
    logic [NREG-1:0]  opEn;
    logic [WIDTH-1:0] readVal;
    logic [WIDTH-1:0] loadData;

    // Selects with no matching register read as 0 and enable nothing.
    always_comb begin
        readVal = '0;
        for (int i = 0; i < NREG; i++) begin
            if (ESEL == AW'(i)) readVal = regQ[i];
        end
    end

    always_comb begin
        ldEn = '0;
        opEn = '0;
        for (int i = 0; i < NREG; i++) begin
            if (LSEL == AW'(i)) begin
                ldEn[i] = !nL;
                opEn[i] = nL;
            end
        end
    end

    // While the bank drives the bus, take the source register directly so a
    // transfer never depends on bus resolution and a self-transfer is a no-op.
    assign loadData = E ? readVal : WBUS;
    assign WBUS     = E ? readVal : {WIDTH{HIZ}};
    assign ZERO     = (readVal == '0);
    assign WRAP     = |wrapVec;

    for (genvar g = 0; g < NREG; g++) begin : gCell
        wbus_reg_cell #(.WIDTH(WIDTH)) uCell (
            .CLK  (CLK),
            .CLR  (CLR),
            .ld   (ldEn[g]),
            .sel  (opEn[g]),
            .din  (loadData),
            .op   (op_e'(OP)),
            .q    (regQ[g]),
            .wrap (wrapVec[g])
        );
    end

endmodule
